jk_cmd_gen: RTL and testbench
=============================

// Module: jk_cmd_gen
// PURPOSE
//   Turns a stream of N-bit target states into JK excitation commands (j,k) for a
//   downstream bank of jk flip-flops. A shadow of the bank state decides each
//   command. It sits between a controller that issues target values and the JK
//   register bank. Both sides use a valid/ready handshake.
// PARAMETERS
//   WIDTH    8  bits per target / number of driven JK flops
//   INIT     0  shadow reset value; must equal the downstream flops' reset state
//   DC_MODE  0  don't-care resolution: 0 = hold (unused input driven 0); 1 = explicit set/reset
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      target request valid
//   in_ready   out  1      request accepted when in_valid && in_ready
//   in_target  in   WIDTH  desired next state of the JK bank
//   out_valid  out  1      command valid
//   out_ready  in   1      downstream applies command on out_valid && out_ready edge
//   out_j      out  WIDTH  J inputs for the bank
//   out_k      out  WIDTH  K inputs for the bank
//   q_obs      in   WIDTH  observed bank outputs (used only with check feature)
//   mismatch   out  1      sticky: observed state diverged from expected
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge):
//     in_ready=1 after reset; out_valid=0; out_j=out_k=0; mismatch=0;
//     shadow=INIT; FIFO emptied. Any reset mid-operation drops all pending commands.
//   - Input buffer: 2-entry FIFO. in_ready = !fifo_full. No pass-through when full.
//   - Push and pop in the same cycle are allowed and leave the occupancy unchanged.
//   - Output stage is a single register. It loads when fifo nonempty && (!out_valid || out_ready).
//   - Latency: a target accepted at edge N gives out_valid=1 after edge N+1 at the earliest.
//   - Per bit, with c=shadow and t=target:
//     DC_MODE=0: j = ~c & t, k = c & ~t (transitions 00->hold, 0->1 j, 1->0 k, 11->hold).
//     DC_MODE=1: j = t, k = ~t. The 11 (toggle) code is never emitted.
//   - Shadow <= target when the output register loads, so back-to-back commands chain correctly.
//   - One command per accepted target, including all-zero (no-change) commands. Order is preserved.
//   - out_j/out_k are stable while out_valid && !out_ready.
//   - Throughput: 1 command/cycle when out_ready is held at 1.
// CONFIGURATION
//   JK_CMD_CHECK_EN defined:
//     - An "applied" register (reset INIT) takes the command's target at each output handshake.
//     - After the first handshake, each cycle compares q_obs with applied.
//     - The first difference sets mismatch at the next edge. It stays set until rst.
//   JK_CMD_CHECK_EN undefined: q_obs ignored; mismatch constant 0; no check logic.
// TESTING (WIDTH=8, INIT=0)
//   1. DC_MODE=0, after reset push 0xA5, out_ready=1 -> next cycle out_valid=1, j=0xA5, k=0x00.
//   2. Then push 0x0F -> j=0x0A, k=0xA0; then push 0x0F again -> j=0x00, k=0x00, out_valid=1.
//   3. out_ready=0, push 0x11, 0x22, 0x33, 0x44 -> output holds 0x11 cmd; 0x22/0x33 buffered;
//      in_ready=0 for 0x44. Then out_ready=1 -> commands for 0x11, 0x22, 0x33, 0x44 in order, no loss.
//   4. DC_MODE=1, after reset push 0x3C -> j=0x3C, k=0xC3; out_j & out_k == 0 on every command.
//   5. FIFO full, assert rst 1 cycle -> out_valid=0, in_ready=1; then push 0xFF -> j=0xFF, k=0x00.
//   6. JK_CMD_CHECK_EN: apply 0xA5, hold q_obs=0x00 -> mismatch=1 and stays 1;
//      with the macro undefined, same stimulus keeps mismatch=0.

Source files
------------

// File: rtl/jk_cmd_gen_if.sv
// Handshake bundle between the target controller, jk_cmd_gen and the downstream JK bank.
// The master side issues targets and consumes commands; the slave side is jk_cmd_gen.
interface jk_cmd_gen_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_j;
  logic [WIDTH-1:0] out_k;
  logic [WIDTH-1:0] q_obs;
  logic             mismatch;

  modport master (
    output in_valid, in_target, out_ready, q_obs,
    input  in_ready, out_valid, out_j, out_k, mismatch
  );

  modport slave (
    input  in_valid, in_target, out_ready, q_obs,
    output in_ready, out_valid, out_j, out_k, mismatch
  );
endinterface

// File: rtl/jk_cmd_gen.sv
// Converts a stream of target states into JK excitation commands using a shadow of the bank state.
// Define JK_CMD_CHECK_EN to compare the observed bank outputs against the applied targets.
module jk_cmd_gen #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter int               DC_MODE = 0
) (
  input logic         clk,
  input logic         rst,
  jk_cmd_gen_if.slave bus
);

  logic [WIDTH-1:0] fifo_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             load;
  logic             out_valid_r;
  logic [WIDTH-1:0] j_r;
  logic [WIDTH-1:0] k_r;
  logic [WIDTH-1:0] next_j;
  logic [WIDTH-1:0] next_k;

  assign bus.in_ready  = (count != 2'd2);
  assign push          = bus.in_valid && bus.in_ready;
  assign load          = (count != 2'd0) && (!out_valid_r || bus.out_ready);
  assign head          = fifo_mem[rd_ptr];
  assign bus.out_valid = out_valid_r;
  assign bus.out_j     = j_r;
  assign bus.out_k     = k_r;

  // Hold mode leaves the unused input of each flop at 0; explicit mode always drives set or reset.
  always_comb begin
    next_j = '0;
    next_k = '0;
    if (DC_MODE == 0) begin
      next_j = ~shadow & head;
      next_k = shadow & ~head;
    end else begin
      next_j = head;
      next_k = ~head;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= bus.in_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      shadow      <= INIT;
      out_valid_r <= 1'b0;
      j_r         <= '0;
      k_r         <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (load) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, load})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // Shadow advances at load time so the next queued target is judged against this one.
      if (load) begin
        out_valid_r <= 1'b1;
        j_r         <= next_j;
        k_r         <= next_k;
        shadow      <= head;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef JK_CMD_CHECK_EN
  logic [WIDTH-1:0] out_target_r;
  logic [WIDTH-1:0] applied;
  logic             started;
  logic             mismatch_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_target_r <= INIT;
      applied      <= INIT;
      started      <= 1'b0;
      mismatch_r   <= 1'b0;
    end else begin
      if (load) begin
        out_target_r <= head;
      end
      if (started && (bus.q_obs != applied)) begin
        mismatch_r <= 1'b1;
      end
      if (out_valid_r && bus.out_ready) begin
        applied <= out_target_r;
        started <= 1'b1;
      end
    end
  end

  assign bus.mismatch = mismatch_r;
`else
  logic unused_q_obs;
  assign unused_q_obs = ^bus.q_obs;
  assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_gen.sv
// Scoreboard bench for jk_cmd_gen: a hold-mode and an explicit-mode instance driven side by side.
// Mismatch expectations follow JK_CMD_CHECK_EN.
module tb_jk_cmd_gen;

  typedef struct packed {
    logic [7:0] j;
    logic [7:0] k;
  } cmd_t;

  logic clk;
  logic rst;
  logic hold_zero;
  logic [7:0] bank0;
  logic [7:0] bank1;
  logic [7:0] sh0;
  cmd_t q0[$];
  cmd_t q1[$];
  int checks;
  int errors;

`ifdef JK_CMD_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  jk_cmd_gen_if #(.WIDTH(8)) b0 ();
  jk_cmd_gen_if #(.WIDTH(8)) b1 ();

  jk_cmd_gen #(.WIDTH(8), .INIT(8'h00), .DC_MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  jk_cmd_gen #(.WIDTH(8), .INIT(8'h00), .DC_MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK banks fed by the commands, so q_obs reflects what a real bank would hold.
  always @(posedge clk) begin
    if (rst) begin
      bank0 <= 8'h00;
      bank1 <= 8'h00;
    end else begin
      if (b0.out_valid && b0.out_ready) bank0 <= (b0.out_j & ~bank0) | (~b0.out_k & bank0);
      if (b1.out_valid && b1.out_ready) bank1 <= (b1.out_j & ~bank1) | (~b1.out_k & bank1);
    end
  end

  assign b0.q_obs = hold_zero ? 8'h00 : bank0;
  assign b1.q_obs = bank1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      checks++;
      assert (q0.size() != 0) else begin
        errors++;
        $error("[TB] FAIL dc0_extra_cmd: observed j=%0h k=%0h expected no command", b0.out_j, b0.out_k);
      end
      if (q0.size() != 0) begin
        cmd_t c;
        c = q0.pop_front();
        checkOutput("dc0_j", {24'd0, b0.out_j}, {24'd0, c.j});
        checkOutput("dc0_k", {24'd0, b0.out_k}, {24'd0, c.k});
      end
    end
    if (!rst && b1.out_valid && b1.out_ready) begin
      checks++;
      assert (q1.size() != 0) else begin
        errors++;
        $error("[TB] FAIL dc1_extra_cmd: observed j=%0h k=%0h expected no command", b1.out_j, b1.out_k);
      end
      if (q1.size() != 0) begin
        cmd_t c;
        c = q1.pop_front();
        checkOutput("dc1_j", {24'd0, b1.out_j}, {24'd0, c.j});
        checkOutput("dc1_k", {24'd0, b1.out_k}, {24'd0, c.k});
        checkOutput("dc1_no_toggle", {24'd0, b1.out_j & b1.out_k}, 32'd0);
      end
    end
  end

  // Drives one target, waits (bounded) for acceptance, then records the expected command.
  task automatic applyStimulus(input bit sel, input logic [7:0] t);
    bit   got;
    cmd_t c;
    got = 1'b0;
    if (sel == 1'b0) begin
      b0.in_valid  = 1'b1;
      b0.in_target = t;
    end else begin
      b1.in_valid  = 1'b1;
      b1.in_target = t;
    end
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = (sel == 1'b0) ? b0.in_ready : b1.in_ready;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("[TB] FAIL accept_timeout: observed in_ready=0 expected 1 for target %0h", t);
    end
    @(posedge clk);
    #1;
    if (sel == 1'b0) begin
      b0.in_valid = 1'b0;
      if (got) begin
        c.j = ~sh0 & t;
        c.k = sh0 & ~t;
        sh0 = t;
        q0.push_back(c);
      end
    end else begin
      b1.in_valid = 1'b0;
      if (got) begin
        c.j = t;
        c.k = ~t;
        q1.push_back(c);
      end
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 50 && (q0.size() != 0 || q1.size() != 0); n++) begin
      @(negedge clk);
    end
    checkOutput("drain_q0", q0.size(), 32'd0);
    checkOutput("drain_q1", q1.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    q0.delete();
    q1.delete();
    sh0 = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    hold_zero    = 1'b0;
    sh0          = 8'h00;
    rst          = 1'b1;
    b0.in_valid  = 1'b0;
    b0.in_target = 8'h00;
    b0.out_ready = 1'b0;
    b1.in_valid  = 1'b0;
    b1.in_target = 8'h00;
    b1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, b0.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, b0.out_valid}, 32'd0);
    checkOutput("rst_out_j", {24'd0, b0.out_j}, 32'd0);
    checkOutput("rst_out_k", {24'd0, b0.out_k}, 32'd0);
    checkOutput("rst_mismatch", {31'd0, b0.mismatch}, 32'd0);
    checkOutput("rst_dc1_out_valid", {31'd0, b1.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] hold mode: single and chained commands");
    b0.out_ready = 1'b1;
    applyStimulus(1'b0, 8'hA5);
    @(negedge clk);
    checkOutput("latency_min", {31'd0, b0.out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("latency_a5", {31'd0, b0.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h0F);
    applyStimulus(1'b0, 8'h0F);
    waitDrain();

    $display("[TB] hold mode: backpressure with full buffer");
    b0.out_ready = 1'b0;
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h22);
    applyStimulus(1'b0, 8'h33);
    @(negedge clk);
    checkOutput("full_in_ready", {31'd0, b0.in_ready}, 32'd0);
    checkOutput("stall_valid", {31'd0, b0.out_valid}, 32'd1);
    checkOutput("stall_j", {24'd0, b0.out_j}, {24'd0, q0[0].j});
    checkOutput("stall_k", {24'd0, b0.out_k}, {24'd0, q0[0].k});
    @(posedge clk);
    #1;
    b0.in_valid  = 1'b1;
    b0.in_target = 8'h44;
    repeat (2) @(negedge clk);
    checkOutput("full_blocks_44", {31'd0, b0.in_ready}, 32'd0);
    checkOutput("stall_j_stable", {24'd0, b0.out_j}, {24'd0, q0[0].j});
    checkOutput("stall_k_stable", {24'd0, b0.out_k}, {24'd0, q0[0].k});
    @(posedge clk);
    #1;
    b0.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h44);
    waitDrain();

    $display("[TB] explicit mode commands");
    b1.out_ready = 1'b1;
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h5A);
    waitDrain();

    $display("[TB] reset with full buffer");
    b0.out_ready = 1'b0;
    applyStimulus(1'b0, 8'h81);
    applyStimulus(1'b0, 8'h42);
    applyStimulus(1'b0, 8'h24);
    @(negedge clk);
    checkOutput("full_before_rst", {31'd0, b0.in_ready}, 32'd0);
    doReset();
    @(negedge clk);
    checkOutput("rst2_out_valid", {31'd0, b0.out_valid}, 32'd0);
    checkOutput("rst2_in_ready", {31'd0, b0.in_ready}, 32'd1);
    checkOutput("rst2_out_j", {24'd0, b0.out_j}, 32'd0);
    checkOutput("rst2_mismatch", {31'd0, b0.mismatch}, 32'd0);
    @(posedge clk);
    #1;
    b0.out_ready = 1'b1;
    applyStimulus(1'b0, 8'hFF);
    waitDrain();
    checkOutput("no_mismatch_normal", {31'd0, b0.mismatch}, 32'd0);

    $display("[TB] observed bank stuck at zero");
    doReset();
    hold_zero = 1'b1;
    applyStimulus(1'b0, 8'hA5);
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("mismatch_set", {31'd0, b0.mismatch}, {31'd0, EXP_MM});
    @(posedge clk);
    #1;
    hold_zero = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mismatch_sticky", {31'd0, b0.mismatch}, {31'd0, EXP_MM});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
